// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state codes, opcode constants and select encodings for ctrl_fsm_mc
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_ADDR     = 5'd2,
    S_MEM_WAIT = 5'd3,
    S_MEM_RD   = 5'd4,
    S_WB_MEM   = 5'd5,
    S_MEM_WR   = 5'd6,
    S_EXEC_R   = 5'd7,
    S_EXEC_I   = 5'd8,
    S_WB_ALU   = 5'd9,
    S_BR_ADDR  = 5'd10,
    S_PC_UPD   = 5'd11,
    S_JUMP     = 5'd12,
    S_FINISH   = 5'd13,
    S_IN_WAIT  = 5'd14,
    S_IN_WB    = 5'd15,
    S_HALT     = 5'd16
  } state_t;

  // Opcodes are 8 bits here and zero-extended/narrowed to OPCODE_W at the comparison.
  localparam logic [7:0] OP_R   = 8'h00;
  localparam logic [7:0] OP_BEQ = 8'h0A;
  localparam logic [7:0] OP_BNE = 8'h0B;
  localparam logic [7:0] OP_BLT = 8'h0C;
  localparam logic [7:0] OP_BGT = 8'h0D;
  localparam logic [7:0] OP_STI = 8'h0E;
  localparam logic [7:0] OP_LDI = 8'h0F;
  localparam logic [7:0] OP_STR = 8'h10;
  localparam logic [7:0] OP_LDR = 8'h11;
  localparam logic [7:0] OP_HLT = 8'h12;
  localparam logic [7:0] OP_IN  = 8'h13;
  localparam logic [7:0] OP_OUT = 8'h14;
  localparam logic [7:0] OP_JMP = 8'h15;
  localparam logic [7:0] OP_JAL = 8'h16;
  localparam logic [7:0] OP_JST = 8'h17;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_HOLD = 2'b01;
  localparam logic [1:0] PC_BR   = 2'b10;
  localparam logic [1:0] PC_STK  = 2'b11;

  localparam logic [1:0] UB_REG = 2'b00;
  localparam logic [1:0] UB_ONE = 2'b01;
  localparam logic [1:0] UB_IMM = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_FN    = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

endpackage

// File: rtl/ctrl_in_handshake.sv
// rtl/ctrl_in_handshake.sv - enter rise-then-fall detector with optional timeout for the IN_WAIT state
module ctrl_in_handshake #(
  parameter int IN_TIMEOUT = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_enter,
  output logic o_in_done,
  output logic o_in_to
);

  logic        r_enter_prev;
  logic        r_armed;
  logic [15:0] r_cnt;

  // prev is tracked continuously so a level already high on entry is not seen as a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_enter_prev <= 1'b0;
      r_armed      <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_enter_prev <= i_enter;
      if (!i_active) begin
        r_armed <= 1'b0;
        r_cnt   <= '0;
      end else begin
        if (i_enter && !r_enter_prev) r_armed <= 1'b1;
        if (IN_TIMEOUT != 0) r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_in_done = i_active && r_armed && r_enter_prev && !i_enter;
  assign o_in_to   = (IN_TIMEOUT != 0) && i_active && !o_in_done &&
                     (r_cnt == 16'(IN_TIMEOUT - 1));

endmodule

// File: rtl/ctrl_fsm_mc.sv
// rtl/ctrl_fsm_mc.sv - multicycle control FSM; CTRL_STACK_GUARD_EN enables return-stack depth guarding
module ctrl_fsm_mc
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int MEM_WAIT    = 0,
  parameter int IN_TIMEOUT  = 0,
  parameter int STACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                enter,
  input  logic                resume,
  output logic [4:0]          estado,
  output logic                EscrevePC,
  output logic                EscreveRI,
  output logic                EscreveReg,
  output logic                EscreveMem,
  output logic                controleOUT,
  output logic                pop,
  output logic                push,
  output logic                SelMuxMem,
  output logic                SelMuxReg1,
  output logic                SelMuxReg2,
  output logic                SelMuxUlaA,
  output logic                SelMuxIn,
  output logic [1:0]          SelMuxUlaB,
  output logic [1:0]          SelMuxPC,
  output logic [1:0]          OpULA,
  output logic                halted,
  output logic                in_timeout,
  output logic                stk_err
);

  state_t     r_state, w_next;
  logic [3:0] r_wait_cnt;
  logic       w_in_done, w_in_to, w_stk_fault;

  logic w_is_r, w_is_sti, w_is_ldi, w_is_str, w_is_ldr, w_is_hlt, w_is_in, w_is_out;
  logic w_is_jmp, w_is_jal, w_is_jst, w_is_br, w_is_load, w_is_mem, w_wait_done;
  state_t w_mem_next;

  assign w_is_r    = (opcode == OPCODE_W'(OP_R));
  assign w_is_sti  = (opcode == OPCODE_W'(OP_STI));
  assign w_is_ldi  = (opcode == OPCODE_W'(OP_LDI));
  assign w_is_str  = (opcode == OPCODE_W'(OP_STR));
  assign w_is_ldr  = (opcode == OPCODE_W'(OP_LDR));
  assign w_is_hlt  = (opcode == OPCODE_W'(OP_HLT));
  assign w_is_in   = (opcode == OPCODE_W'(OP_IN));
  assign w_is_out  = (opcode == OPCODE_W'(OP_OUT));
  assign w_is_jmp  = (opcode == OPCODE_W'(OP_JMP));
  assign w_is_jal  = (opcode == OPCODE_W'(OP_JAL));
  assign w_is_jst  = (opcode == OPCODE_W'(OP_JST));
  assign w_is_br   = (opcode == OPCODE_W'(OP_BEQ)) || (opcode == OPCODE_W'(OP_BNE)) ||
                     (opcode == OPCODE_W'(OP_BLT)) || (opcode == OPCODE_W'(OP_BGT));
  assign w_is_load = w_is_ldi || w_is_ldr;
  assign w_is_mem  = w_is_load || w_is_sti || w_is_str;
  assign w_mem_next  = w_is_load ? S_MEM_RD : S_MEM_WR;
  assign w_wait_done = (r_wait_cnt == 4'(MEM_WAIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= (r_state == S_MEM_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
    end
  end

  ctrl_in_handshake #(.IN_TIMEOUT(IN_TIMEOUT)) u_in_hs (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_active  (r_state == S_IN_WAIT),
    .i_enter   (enter),
    .o_in_done (w_in_done),
    .o_in_to   (w_in_to)
  );

`ifdef CTRL_STACK_GUARD_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);
  logic [DW-1:0] r_depth;
  logic          r_stk_err;

  // A faulting jal/jst is caught in DECODE, so the depth never leaves 0..STACK_DEPTH.
  assign w_stk_fault = (r_state == S_DECODE) &&
                       ((w_is_jal && (r_depth == DW'(STACK_DEPTH))) || (w_is_jst && (r_depth == '0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth   <= '0;
      r_stk_err <= 1'b0;
    end else begin
      if (w_stk_fault) r_stk_err <= 1'b1;
      if ((r_state == S_FINISH) && w_is_jal)      r_depth <= r_depth + 1'b1;
      else if ((r_state == S_PC_UPD) && w_is_jst) r_depth <= r_depth - 1'b1;
    end
  end
  assign stk_err = r_stk_err;
`else
  assign w_stk_fault = 1'b0;
  assign stk_err     = 1'b0;
`endif

  assign estado     = r_state;
  assign in_timeout = w_in_to;

  always_comb begin
    w_next      = r_state;
    EscrevePC   = 1'b0;
    EscreveRI   = 1'b0;
    EscreveReg  = 1'b0;
    EscreveMem  = 1'b0;
    controleOUT = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    SelMuxMem   = 1'b0;
    SelMuxReg1  = 1'b0;
    SelMuxReg2  = 1'b0;
    SelMuxUlaA  = 1'b0;
    SelMuxIn    = 1'b0;
    SelMuxUlaB  = UB_REG;
    SelMuxPC    = PC_ALU;
    OpULA       = 2'b00;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        EscreveRI  = 1'b1;
        SelMuxUlaB = UB_ONE;
        SelMuxIn   = 1'b1;
        OpULA      = ALU_ADD;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        EscrevePC   = !w_is_hlt && !w_stk_fault;
        controleOUT = w_is_out;
        SelMuxUlaB  = UB_ONE;
        OpULA       = ALU_ADD;
        if (w_stk_fault)   w_next = S_HALT;
        else if (w_is_out) w_next = S_FETCH;
        else if (w_is_in)  w_next = S_IN_WAIT;
        else if (w_is_mem) w_next = S_ADDR;
        else if (w_is_r)   w_next = S_EXEC_R;
        else if (w_is_br)  w_next = S_BR_ADDR;
        else if (w_is_jmp || w_is_jal) w_next = S_JUMP;
        else if (w_is_jst) w_next = S_PC_UPD;
        else if (w_is_hlt) w_next = S_HALT;
        else               w_next = S_EXEC_I;
      end
      S_ADDR, S_MEM_WAIT: begin
        SelMuxUlaA = 1'b1;
        SelMuxUlaB = UB_IMM;
        SelMuxMem  = 1'b1;
        OpULA      = (w_is_sti || w_is_ldi) ? ALU_PASSB : ALU_ADD;
        if (r_state == S_ADDR) w_next = (MEM_WAIT > 0) ? S_MEM_WAIT : w_mem_next;
        else                   w_next = w_wait_done ? w_mem_next : S_MEM_WAIT;
      end
      S_MEM_RD: begin
        SelMuxMem = 1'b1;
        w_next    = S_WB_MEM;
      end
      S_WB_MEM: begin
        EscreveReg = 1'b1;
        SelMuxReg2 = 1'b1;
        w_next     = S_FINISH;
      end
      S_MEM_WR: begin
        SelMuxMem  = 1'b1;
        EscreveMem = 1'b1;
        w_next     = S_FINISH;
      end
      S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
        // ALU operands stay selected through WB_ALU so the written result is stable.
        SelMuxReg1 = w_is_r;
        SelMuxUlaB = w_is_r ? UB_REG : UB_IMM;
        OpULA      = ALU_FN;
        EscreveReg = (r_state == S_WB_ALU);
        w_next     = (r_state == S_WB_ALU) ? S_FETCH : S_WB_ALU;
      end
      S_BR_ADDR: begin
        SelMuxPC = PC_HOLD;
        w_next   = S_PC_UPD;
      end
      S_PC_UPD: begin
        if (w_is_jst) begin
          EscrevePC = 1'b1;
          pop       = 1'b1;
          SelMuxPC  = PC_STK;
        end else begin
          EscrevePC = zero;
          SelMuxPC  = PC_BR;
        end
        w_next = S_FETCH;
      end
      S_JUMP: begin
        EscrevePC  = 1'b1;
        OpULA      = ALU_PASSB;
        SelMuxUlaB = UB_IMM;
        w_next     = S_FINISH;
      end
      S_FINISH: begin
        push   = w_is_jal;
        w_next = S_FETCH;
      end
      S_IN_WAIT: begin
        if (w_in_done || w_in_to) w_next = S_IN_WB;
      end
      S_IN_WB: begin
        EscreveReg = 1'b1;
        SelMuxIn   = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// tb/tb_ctrl_fsm_mc.sv - directed self-checking bench for ctrl_fsm_mc (MEM_WAIT=3, IN_TIMEOUT=20, STACK_DEPTH=2)
module tb_ctrl_fsm_mc;

  localparam logic [4:0] FETCH = 5'd0, DECODE = 5'd1, ADDR = 5'd2, MWAIT = 5'd3, MEM_RD = 5'd4,
                         WB_MEM = 5'd5, MEM_WR = 5'd6, EXEC_R = 5'd7, EXEC_I = 5'd8, WB_ALU = 5'd9,
                         BR_ADDR = 5'd10, PC_UPD = 5'd11, JUMP = 5'd12, FINISH = 5'd13,
                         IN_WAIT = 5'd14, IN_WB = 5'd15, HALT = 5'd16;

  logic       clk = 1'b0;
  logic       reset, zero, enter, resume;
  logic [5:0] opcode;
  logic [4:0] estado;
  logic       EscrevePC, EscreveRI, EscreveReg, EscreveMem, controleOUT, pop, push;
  logic       SelMuxMem, SelMuxReg1, SelMuxReg2, SelMuxUlaA, SelMuxIn;
  logic [1:0] SelMuxUlaB, SelMuxPC, OpULA;
  logic       halted, in_timeout, stk_err;

  int n_pass = 0;
  int n_total = 0;

  ctrl_fsm_mc #(.OPCODE_W(6), .MEM_WAIT(3), .IN_TIMEOUT(20), .STACK_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .enter(enter), .resume(resume),
    .estado(estado), .EscrevePC(EscrevePC), .EscreveRI(EscreveRI), .EscreveReg(EscreveReg),
    .EscreveMem(EscreveMem), .controleOUT(controleOUT), .pop(pop), .push(push),
    .SelMuxMem(SelMuxMem), .SelMuxReg1(SelMuxReg1), .SelMuxReg2(SelMuxReg2),
    .SelMuxUlaA(SelMuxUlaA), .SelMuxIn(SelMuxIn), .SelMuxUlaB(SelMuxUlaB),
    .SelMuxPC(SelMuxPC), .OpULA(OpULA), .halted(halted), .in_timeout(in_timeout),
    .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] others;
    reset = 1'b0; opcode = 6'h00; zero = 1'b0; enter = 1'b0; resume = 1'b0;
    #12;
    others = {EscrevePC, EscreveReg, EscreveMem, controleOUT, pop, push, SelMuxMem, SelMuxReg1,
              SelMuxReg2, SelMuxUlaA, SelMuxPC, halted, in_timeout};
    n_total++;
    if (estado !== FETCH || EscreveRI !== 1'b1 || SelMuxUlaB !== 2'b01 || SelMuxIn !== 1'b1 ||
        OpULA !== 2'b01)
      $display("FAIL reset_decode: estado=%0d RI=%b UlaB=%b In=%b OpULA=%b (want 0 1 01 1 01)",
               estado, EscreveRI, SelMuxUlaB, SelMuxIn, OpULA);
    else n_pass++;
    n_total++;
    if (others !== 14'd0 || stk_err !== 1'b0)
      $display("FAIL reset_zero_outputs: others=%b stk_err=%b want all 0", others, stk_err);
    else n_pass++;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_r_add();
    logic [4:0] seq [0:3];
    logic       wr  [0:3];
    seq = '{FETCH, DECODE, EXEC_R, WB_ALU};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b1};
    opcode = 6'h00;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (estado !== seq[i] || EscreveReg !== wr[i])
        $display("FAIL r_add cyc%0d: estado=%0d EscreveReg=%b want %0d %b", i, estado, EscreveReg, seq[i], wr[i]);
      else n_pass++;
      tick();
    end
    n_total++;
    if (estado !== FETCH) $display("FAIL r_add_end: estado=%0d want %0d", estado, FETCH);
    else n_pass++;
  endtask

  task automatic test_load_wait();
    logic [4:0] seq [0:8];
    logic       wr  [0:8];
    seq = '{FETCH, DECODE, ADDR, MWAIT, MWAIT, MWAIT, MEM_RD, WB_MEM, FINISH};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'h11;
    for (int i = 0; i < 9; i++) begin
      n_total++;
      if (estado !== seq[i] || EscreveReg !== wr[i])
        $display("FAIL ldr cyc%0d: estado=%0d EscreveReg=%b want %0d %b", i, estado, EscreveReg, seq[i], wr[i]);
      else n_pass++;
      tick();
    end
    n_total++;
    if (estado !== FETCH) $display("FAIL ldr_9cycles: estado=%0d want %0d", estado, FETCH);
    else n_pass++;
  endtask

  task automatic test_store();
    logic [4:0] seq [0:7];
    seq = '{FETCH, DECODE, ADDR, MWAIT, MWAIT, MWAIT, MEM_WR, FINISH};
    opcode = 6'h0E;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (estado !== seq[i] || EscreveMem !== (i == 6))
        $display("FAIL sti cyc%0d: estado=%0d EscreveMem=%b want %0d %b", i, estado, EscreveMem, seq[i], (i == 6));
      else n_pass++;
      if (i == 2) begin
        n_total++;
        if (OpULA !== 2'b11 || SelMuxUlaA !== 1'b1 || SelMuxUlaB !== 2'b11 || SelMuxMem !== 1'b1)
          $display("FAIL sti_addr_sel: OpULA=%b UlaA=%b UlaB=%b Mem=%b want 11 1 11 1", OpULA, SelMuxUlaA, SelMuxUlaB, SelMuxMem);
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if (estado !== FETCH) $display("FAIL sti_end: estado=%0d want %0d", estado, FETCH);
    else n_pass++;
  endtask

  task automatic test_branch();
    logic [4:0] seq [0:3];
    seq = '{FETCH, DECODE, BR_ADDR, PC_UPD};
    opcode = 6'h0A;
    for (int z = 0; z < 2; z++) begin
      zero = z[0];
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (estado !== seq[i]) $display("FAIL beq z%0d cyc%0d: estado=%0d want %0d", z, i, estado, seq[i]);
        else n_pass++;
        if (i == 3) begin
          n_total++;
          if (EscrevePC !== z[0] || SelMuxPC !== 2'b10)
            $display("FAIL beq_pc_upd z%0d: EscrevePC=%b SelMuxPC=%b want %b 10", z, EscrevePC, SelMuxPC, z[0]);
          else n_pass++;
        end
        tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] seq [0:6];
    seq = '{FETCH, DECODE, FETCH, DECODE, EXEC_I, WB_ALU, FETCH};
    opcode = 6'h14;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (estado !== seq[i] || controleOUT !== (i == 1))
        $display("FAIL out_addi cyc%0d: estado=%0d controleOUT=%b want %0d %b", i, estado, controleOUT, seq[i], (i == 1));
      else n_pass++;
      if (i == 2) opcode = 6'h01;
      if (i < 6) tick();
    end
  endtask

  task automatic test_in_handshake();
    logic       ev [0:3];
    logic [4:0] ex [0:3];
    ev = '{1'b1, 1'b0, 1'b1, 1'b0};
    ex = '{IN_WAIT, IN_WAIT, IN_WAIT, IN_WB};
    opcode = 6'h13;
    enter = 1'b1;
    tick();
    tick();
    n_total++;
    if (estado !== IN_WAIT) $display("FAIL in_entry: estado=%0d want %0d", estado, IN_WAIT);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      enter = ev[i];
      tick();
      n_total++;
      if (estado !== ex[i]) $display("FAIL in_edge step%0d: estado=%0d want %0d", i, estado, ex[i]);
      else n_pass++;
    end
    n_total++;
    if (EscreveReg !== 1'b1 || SelMuxIn !== 1'b1 || in_timeout !== 1'b0)
      $display("FAIL in_wb: EscreveReg=%b SelMuxIn=%b in_timeout=%b want 1 1 0", EscreveReg, SelMuxIn, in_timeout);
    else n_pass++;
    tick();
  endtask

  task automatic test_in_timeout();
    opcode = 6'h13;
    enter = 1'b0;
    tick();
    tick();
    for (int k = 1; k <= 20; k++) begin
      n_total++;
      if (estado !== IN_WAIT || in_timeout !== (k == 20))
        $display("FAIL in_to cyc%0d: estado=%0d in_timeout=%b want %0d %b", k, estado, in_timeout, IN_WAIT, (k == 20));
      else n_pass++;
      tick();
    end
    n_total++;
    if (estado !== IN_WB || in_timeout !== 1'b0)
      $display("FAIL in_to_wb: estado=%0d in_timeout=%b want %0d 0", estado, in_timeout, IN_WB);
    else n_pass++;
    tick();
  endtask

  task automatic test_halt();
    int bad = 0;
    opcode = 6'h12;
    tick();
    n_total++;
    if (estado !== DECODE || EscrevePC !== 1'b0)
      $display("FAIL hlt_decode: estado=%0d EscrevePC=%b want %0d 0", estado, EscrevePC, DECODE);
    else n_pass++;
    tick();
    for (int i = 0; i < 100; i++) begin
      if (estado !== HALT || halted !== 1'b1 ||
          {EscrevePC, EscreveRI, EscreveReg, EscreveMem, pop, push} !== 6'd0) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL hlt_hold: %0d bad cycles of 100 want 0", bad);
    else n_pass++;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    n_total++;
    if (estado !== FETCH || halted !== 1'b0)
      $display("FAIL hlt_resume: estado=%0d halted=%b want %0d 0", estado, halted, FETCH);
    else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    int bad = 0;
    opcode = 6'h10;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (estado !== MWAIT) $display("FAIL str_pre_reset: estado=%0d want %0d", estado, MWAIT);
    else n_pass++;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (estado !== FETCH || EscreveMem !== 1'b0) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL str_reset_abort: %0d bad cycles want 0", bad);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic run_jal(input int idx);
    logic [4:0] seq [0:3];
    seq = '{FETCH, DECODE, JUMP, FINISH};
    opcode = 6'h16;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (estado !== seq[i] || push !== (i == 3) || stk_err !== 1'b0)
        $display("FAIL jal%0d cyc%0d: estado=%0d push=%b stk_err=%b want %0d %b 0", idx, i, estado, push, stk_err, seq[i], (i == 3));
      else n_pass++;
      tick();
    end
  endtask

`ifdef CTRL_STACK_GUARD_EN
  task automatic test_stack();
    run_jal(0);
    run_jal(1);
    opcode = 6'h16;
    tick();
    n_total++;
    if (estado !== DECODE || EscrevePC !== 1'b0 || push !== 1'b0)
      $display("FAIL jal_full_decode: estado=%0d EscrevePC=%b push=%b want %0d 0 0", estado, EscrevePC, push, DECODE);
    else n_pass++;
    tick();
    n_total++;
    if (estado !== HALT || stk_err !== 1'b1 || push !== 1'b0)
      $display("FAIL jal_full_halt: estado=%0d stk_err=%b push=%b want %0d 1 0", estado, stk_err, push, HALT);
    else n_pass++;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    n_total++;
    if (estado !== FETCH || stk_err !== 1'b1)
      $display("FAIL stk_err_sticky: estado=%0d stk_err=%b want %0d 1", estado, stk_err, FETCH);
    else n_pass++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_total++;
    if (stk_err !== 1'b0) $display("FAIL stk_err_reset: stk_err=%b want 0", stk_err);
    else n_pass++;
    opcode = 6'h17;
    tick();
    n_total++;
    if (EscrevePC !== 1'b0 || pop !== 1'b0) $display("FAIL jst_empty_decode: EscrevePC=%b pop=%b want 0 0", EscrevePC, pop);
    else n_pass++;
    tick();
    n_total++;
    if (estado !== HALT || stk_err !== 1'b1 || pop !== 1'b0)
      $display("FAIL jst_empty_halt: estado=%0d stk_err=%b pop=%b want %0d 1 0", estado, stk_err, pop, HALT);
    else n_pass++;
    resume = 1'b1;
    tick();
    resume = 1'b0;
  endtask
`else
  task automatic test_stack();
    run_jal(0);
    run_jal(1);
    run_jal(2);
    opcode = 6'h17;
    tick();
    tick();
    n_total++;
    if (estado !== PC_UPD || pop !== 1'b1 || EscrevePC !== 1'b1 || SelMuxPC !== 2'b11 || stk_err !== 1'b0)
      $display("FAIL jst_pop: estado=%0d pop=%b EscrevePC=%b SelMuxPC=%b stk_err=%b want %0d 1 1 11 0",
               estado, pop, EscrevePC, SelMuxPC, stk_err, PC_UPD);
    else n_pass++;
    tick();
    n_total++;
    if (estado !== FETCH) $display("FAIL jst_end: estado=%0d want %0d", estado, FETCH);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_r_add();
    test_load_wait();
    test_store();
    test_branch();
    test_back_to_back();
    test_in_handshake();
    test_in_timeout();
    test_halt();
    test_reset_mid_store();
    test_stack();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
